// File: rtl/alu_pipe_pkg.sv
// Shared opcode, flag-position and shift-width definitions for alu_pipe.
// Optional MUL opcode is enabled by the ALU_PIPE_MUL_EN macro in the users of this package.
package alu_pipe_pkg;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_MUL  = 4'b1101;

    // Flag bits sit below the result in the packed stage word.
    localparam int FLG_ILLEGAL = 0;
    localparam int FLG_CARRY   = 1;
    localparam int FLG_OVF     = 2;
    localparam int FLG_ZERO    = 3;
    localparam int FLAG_W      = 4;

    function automatic int shamt_w(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (a, b, aluop) -> result and status flags.
// MUL (1101) exists only when ALU_PIPE_MUL_EN is defined.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic [WIDTH-1:0] s,
    output logic             iszero,
    output logic             ovf,
    output logic             carry,
    output logic             illegal
);
    localparam int SHW = shamt_w(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [SHW-1:0]   shamt;
`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] prod;
`endif

    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        // a + ~b + 1: top bit is the not-borrow of a - b
        dif   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        shamt = b[SHW-1:0];
`ifdef ALU_PIPE_MUL_EN
        prod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif
        s       = '0;
        ovf     = 1'b0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (aluop)
            ALU_AND:  s = a & b;
            ALU_OR:   s = a | b;
            ALU_XOR:  s = a ^ b;
            ALU_NOR:  s = ~(a | b);
            ALU_ADD: begin
                s     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                s     = dif[WIDTH-1:0];
                carry = dif[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  s[0] = $signed(a) < $signed(b);
            ALU_SLTU: s[0] = a < b;
            ALU_SLL:  s = a << shamt;
            ALU_SRL:  s = a >> shamt;
            ALU_SRA:  s = $unsigned($signed(a) >>> shamt);
`ifdef ALU_PIPE_MUL_EN
            ALU_MUL: begin
                s   = prod[WIDTH-1:0];
                ovf = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default:  illegal = 1'b1;
        endcase
        iszero = (s == '0);
    end
endmodule

// File: rtl/alu_pipe.sv
// Valid/ready pipelined ALU: operand stage, combinational core, then STAGES-1 result stages.
// Build option ALU_PIPE_MUL_EN adds the MUL opcode inside alu_core.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             iszero,
    output logic             ovf,
    output logic             carry,
    output logic             illegal
);
    localparam int RW = WIDTH + FLAG_W;

    logic [STAGES:1]  vld_pipe_q, vld_pipe_d, adv;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             accept;
    logic [WIDTH-1:0] core_s;
    logic             core_z, core_o, core_c, core_i;
    logic [RW-1:0]    core_res, out_res;

    // A stage advances if it is empty or everything downstream of it moves.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            adv[k] = !vld_pipe_q[k] || nxt;
            nxt    = adv[k];
        end
    end

    assign in_ready = adv[1];
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (adv[1]) vld_pipe_d[1] = in_valid;
        for (int k = 2; k <= STAGES; k++)
            if (adv[k]) vld_pipe_d[k] = vld_pipe_q[k-1];
        a_d  = accept ? a     : a_q;
        b_d  = accept ? b     : b_q;
        op_d = accept ? aluop : op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
        end
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a       (a_q),
        .b       (b_q),
        .aluop   (op_q),
        .s       (core_s),
        .iszero  (core_z),
        .ovf     (core_o),
        .carry   (core_c),
        .illegal (core_i)
    );

    always_comb begin
        core_res                  = '0;
        core_res[RW-1:FLAG_W]     = core_s;
        core_res[FLG_ZERO]        = core_z;
        core_res[FLG_OVF]         = core_o;
        core_res[FLG_CARRY]       = core_c;
        core_res[FLG_ILLEGAL]     = core_i;
    end

    generate
        if (STAGES == 1) begin : g_one
            // Operand regs reset to an AND of zeros, so mask to keep idle outputs at 0.
            assign out_res = vld_pipe_q[1] ? core_res : '0;
        end else begin : g_multi
            logic [STAGES:2][RW-1:0] res_q, res_d;

            always_comb begin
                res_d = res_q;
                if (adv[2] && vld_pipe_q[1]) res_d[2] = core_res;
                for (int k = 3; k <= STAGES; k++)
                    if (adv[k] && vld_pipe_q[k-1]) res_d[k] = res_q[k-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) res_q <= '0;
                else        res_q <= res_d;
            end

            assign out_res = res_q[STAGES];
        end
    endgenerate

    assign out_valid = vld_pipe_q[STAGES];
    assign s         = out_res[RW-1:FLAG_W];
    assign iszero    = out_res[FLG_ZERO];
    assign ovf       = out_res[FLG_OVF];
    assign carry     = out_res[FLG_CARRY];
    assign illegal   = out_res[FLG_ILLEGAL];
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, random traffic with random
// backpressure against an arithmetic reference model, stall hold and mid-flight reset.
module tb_alu_pipe;
    localparam int W  = 32;
    localparam int ST = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, s;
    logic [3:0]    aluop;
    logic          iszero, ovf, carry, illegal;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .aluop(aluop), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .iszero(iszero), .ovf(ovf), .carry(carry), .illegal(illegal)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         z, o, c, i;
    } res_t;

    res_t exp_q[$];
    int   cyc_q[$];
    int   n_tests = 0, n_fail = 0, cyc = 0, n_acc;
    bit   exact = 1'b1, acc_r;
    res_t held;

    logic [3:0]   d_op [14] = '{4'b0010, 4'b0010, 4'b0111, 4'b0101, 4'b1010, 4'b1000, 4'b1101,
                                4'b0110, 4'b0110, 4'b1001, 4'b0100, 4'b1011, 4'b1110, 4'b1111};
    logic [W-1:0] d_a  [14] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                32'h1, 32'h3, 32'h0, 32'h80000000, 32'h80000000, 32'h5, 32'h5, 32'h5, 32'h5};
    logic [W-1:0] d_b  [14] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'd31, 32'd32, 32'h5,
                                32'h1, 32'h1, 32'd33, 32'h3, 32'h3, 32'h3, 32'h3};
    logic [3:0]   s_op [6]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    logic [W-1:0] corners [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

    // Reference: true-integer arithmetic, then wrap to W bits.
    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        res_t            r;
        longint          sa, sb, t;
        longint unsigned ua, ub, p;
        int              sh;
        r  = '0;
        sa = $signed(av);  sb = $signed(bv);
        ua = av;           ub = bv;
        sh = int'(bv % W);
        case (op)
            4'b0000: r.s = av & bv;
            4'b0001: r.s = av | bv;
            4'b0011: r.s = av ^ bv;
            4'b1100: r.s = ~(av | bv);
            4'b0010: begin
                r.s = av + bv;
                r.c = ((ua + ub) >> 32) != 0;
                r.o = (sa + sb) != longint'($signed(r.s));
            end
            4'b0110: begin
                r.s = av - bv;
                r.c = ua >= ub;
                r.o = (sa - sb) != longint'($signed(r.s));
            end
            4'b0111: r.s = (sa < sb) ? 32'd1 : 32'd0;
            4'b0101: r.s = (ua < ub) ? 32'd1 : 32'd0;
            4'b1000: r.s = av << sh;
            4'b1001: r.s = av >> sh;
            4'b1010: begin t = sa >>> sh; r.s = t[W-1:0]; end
`ifdef ALU_PIPE_MUL_EN
            4'b1101: begin p = ua * ub; r.s = p[W-1:0]; r.o = (p >> 32) != 0; end
`endif
            default: r.i = 1'b1;
        endcase
        p = 0;
        r.z = (r.s == 0);
        return r;
    endfunction

    function automatic res_t obs_now();
        return {s, iszero, ovf, carry, illegal};
    endfunction

    task automatic check(input string tag, input res_t obs, input res_t expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got s=%h z%0b o%0b c%0b i%0b, expected s=%h z%0b o%0b c%0b i%0b", tag,
                   obs.s, obs.z, obs.o, obs.c, obs.i, expv.s, expv.z, expv.o, expv.c, expv.i);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock: score retires/accepts at the falling edge, return 1 after the rising edge.
    task automatic tick();
        res_t e;
        int   c0;
        @(negedge clk);
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            n_tests++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL spurious_retire: got out_valid=1 s=%h expected no pending op", s);
            end
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                c0 = cyc_q.pop_front();
                check("retire", obs_now(), e);
                if (exact) chk_int("latency", cyc - c0, ST);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(aluop, a, b));
            cyc_q.push_back(cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1; aluop = op; a = av; b = bv;
        for (int t = 0; t < 50 && !acc; t++) begin
            acc = in_ready;
            tick();
        end
        chk_int("send_accept", int'(acc), 1);
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
        chk_int("drain_empty", exp_q.size(), 0);
    endtask

    function automatic logic [W-1:0] pick();
        if ($urandom_range(2) == 0) return corners[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; aluop = '0;

        // Reset values
        #12;
        check("reset_out", obs_now(), '0);
        chk_int("reset_out_valid", int'(out_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_int("in_ready_after_reset", int'(in_ready), 1);

        // Back-to-back stream at full throughput, exact latency
        exact = 1'b1;
        foreach (s_op[k]) send(s_op[k], 32'd2, 32'd1);
        drain();

        // Directed corner vectors, including illegal codes and 1101
        foreach (d_op[k]) send(d_op[k], d_a[k], d_b[k]);
        drain();

        // Random traffic with random backpressure; source holds when not accepted
        exact = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 400; t++) begin
            out_ready = ($urandom_range(3) != 0);
            #1;
            acc_r = in_valid && in_ready;
            tick();
            if (!in_valid || acc_r) begin
                in_valid = ($urandom_range(2) != 0);
                a = pick(); b = pick(); aluop = 4'($urandom_range(15));
            end
        end
        drain();

        // Fill with consumer stalled, then hold for 5 cycles
        out_ready = 1'b0; in_valid = 1'b1; n_acc = 0;
        aluop = 4'b0010; a = 32'h10; b = 32'h20;
        for (int t = 0; t < 10 && in_ready; t++) begin
            acc_r = in_ready;
            tick();
            if (acc_r) begin n_acc++; a = a + 32'h100; aluop = 4'b0110; end
        end
        chk_int("fill_count", n_acc, ST);
        held = obs_now();
        for (int t = 0; t < 5; t++) begin
            tick();
            check("stall_hold", obs_now(), held);
            chk_int("stall_in_ready", int'(in_ready), 0);
            chk_int("stall_out_valid", int'(out_valid), 1);
        end
        drain();

        // Asynchronous reset with two ops in flight
        out_ready = 1'b0;
        send(4'b0001, 32'h5, 32'hA);
        send(4'b0010, 32'h5, 32'hA);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_int("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out", obs_now(), '0);
        exp_q.delete();
        cyc_q.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_int("post_reset_in_ready", int'(in_ready), 1);
        for (int t = 0; t < 6; t++) begin
            tick();
            chk_int("post_reset_no_retire", int'(out_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
